// File: rtl/alu_sequencer.sv
// Request-side controller for the 64-bit combinational ALU: sequences single-cycle ops
// and a shift-add multiply through the ALU, returning result and {Z,N,C,V} over valid/ready.
module alu_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_result,
    output logic [3:0]  resp_status,
    output logic [4:0]  alu_fs,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic        alu_cin,
    input  logic [63:0] alu_f,
    input  logic        alu_cout,
    input  logic [3:0]  alu_status
);
    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_LSL = 3'd5, OP_LSR = 3'd6, OP_MUL = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL_ADD, S_MUL_SHL, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic [63:0] r_acc, r_mcand, r_mplier, r_result;
    logic [3:0]  r_status;
    logic [4:0]  w_fs;
    logic [63:0] w_a, w_b;
    logic        w_cin;
    logic        w_unused_cout;

    // Carry comes from the ALU status word, so the dedicated carry-out is not needed.
    assign w_unused_cout = alu_cout;

    // Returns {fs, cin}; subtraction is A + ~B + 1.
    function automatic logic [5:0] op_decode(input logic [2:0] op);
        case (op)
            OP_AND:  op_decode = 6'b00000_0;
            OP_OR:   op_decode = 6'b00100_0;
            OP_ADD:  op_decode = 6'b01000_0;
            OP_SUB:  op_decode = 6'b01010_1;
            OP_XOR:  op_decode = 6'b01100_0;
            OP_LSL:  op_decode = 6'b10000_0;
            OP_LSR:  op_decode = 6'b10100_0;
            default: op_decode = 6'b00000_0;
        endcase
    endfunction

    always_comb begin
        w_next = r_state;
        w_fs   = 5'd0;
        w_a    = 64'd0;
        w_b    = 64'd0;
        w_cin  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = (req_op == OP_MUL) ? S_MUL_ADD : S_EXEC;
            end
            S_EXEC: begin
                {w_fs, w_cin} = op_decode(r_op);
                w_a = r_mcand;
                w_b = (r_op == OP_LSL || r_op == OP_LSR) ? {58'd0, r_mplier[5:0]} : r_mplier;
                w_next = S_RESP;
            end
            S_MUL_ADD: begin
                if (r_mplier == 64'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_fs   = 5'b01000;
                    w_a    = r_acc;
                    w_b    = r_mplier[0] ? r_mcand : 64'd0;
                    w_next = S_MUL_SHL;
                end
            end
            S_MUL_SHL: begin
                w_fs   = 5'b10000;
                w_a    = r_mcand;
                w_b    = 64'd1;
                w_next = S_MUL_ADD;
            end
            S_RESP: begin
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Non-MUL operands reuse the multiplicand/multiplier registers as A/B.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= 3'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 64'd0;
            r_result <= 64'd0;
            r_status <= 4'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_acc    <= 64'd0;
                        r_mcand  <= req_a;
                        r_mplier <= req_b;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_f;
                    r_status <= alu_status;
                end
                S_MUL_ADD: begin
                    if (r_mplier == 64'd0) begin
                        r_result <= r_acc;
                        r_status <= {r_acc == 64'd0, r_acc[63], 2'b00};
                    end else begin
                        r_acc <= alu_f;
                    end
                end
                S_MUL_SHL: begin
                    r_mcand  <= alu_f;
                    r_mplier <= r_mplier >> 1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_result = r_result;
    assign resp_status = r_status;
    assign alu_fs      = w_fs;
    assign alu_a       = w_a;
    assign alu_b       = w_b;
    assign alu_cin     = w_cin;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU attached to the ALU port, directed and random
// requests compared against an arithmetic reference model.
module tb_alu_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [63:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_result;
    logic [3:0]  resp_status;
    logic [4:0]  alu_fs;
    logic [63:0] alu_a, alu_b, alu_f;
    logic        alu_cin, alu_cout;
    logic [3:0]  alu_status;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_status(resp_status),
        .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_status(alu_status)
    );

    // Combinational ALU attached to the sequencer.
    logic [63:0] m_opa, m_opb, m_f;
    logic [64:0] m_sum;
    logic        m_c, m_v;
    always_comb begin
        m_opa = alu_fs[0] ? ~alu_a : alu_a;
        m_opb = alu_fs[1] ? ~alu_b : alu_b;
        m_sum = {1'b0, m_opa} + {1'b0, m_opb} + {64'd0, alu_cin};
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_fs[4:2])
            3'b000: m_f = m_opa & m_opb;
            3'b001: m_f = m_opa | m_opb;
            3'b010: begin
                m_f = m_sum[63:0];
                m_c = m_sum[64];
                m_v = (m_opa[63] == m_opb[63]) && (m_f[63] != m_opa[63]);
            end
            3'b011: m_f = m_opa ^ m_opb;
            3'b100: m_f = m_opa << m_opb[5:0];
            3'b101: m_f = m_opa >> m_opb[5:0];
            default: m_f = 64'd0;
        endcase
    end
    assign alu_f      = m_f;
    assign alu_cout   = m_c;
    assign alu_status = {m_f == 64'd0, m_f[63], m_c, m_v};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic [3:0] s);
        logic c, v;
        logic [5:0] sh;
        c = 1'b0; v = 1'b0; sh = b[5:0];
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[63] == b[63]) && (r[63] != a[63]); end
            3'd3: begin r = a - b; c = (a >= b); v = (a[63] != b[63]) && (r[63] != a[63]); end
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: r = a * b;
        endcase
        s = {r == 64'd0, r[63], c, v};
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [63:0] b);
        int n;
        if (op != 3'd7) return 1;
        n = 0;
        for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
        return 2 * n + 1;
    endfunction

    function automatic logic [5:0] exp_fs_cin(input logic [2:0] op);
        case (op)
            3'd0: return 6'b00000_0;
            3'd1: return 6'b00100_0;
            3'd2: return 6'b01000_0;
            3'd3: return 6'b01010_1;
            3'd4: return 6'b01100_0;
            3'd5: return 6'b10000_0;
            default: return 6'b10100_0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] er;
        logic [3:0]  es;
        int w, lat;
        bit got;
        ref_model(op, a, b, er, es);
        resp_ready = 1'b0;
        @(negedge clock);
        w = 0;
        while (!req_ready && w < 300) begin @(negedge clock); w++; end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (op != 3'd7) chk("exec_fs_cin", {alu_fs, alu_cin}, exp_fs_cin(op));
        lat = 0; got = 0;
        while (!got && lat < 300) begin
            @(posedge clock); #1; lat++;
            if (resp_valid) got = 1;
        end
        chk("latency", lat, exp_lat(op, b));
        chk("result", resp_result, er);
        chk("status", resp_status, es);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_result", resp_result, er);
            chk("hold_valid_ready", {resp_valid, req_ready}, 2'b10);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("after_resp", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  bop [3];
        logic [63:0] ba [3], bb [3];
        logic [63:0] er;
        logic [3:0]  es;
        int acc_cyc [3];
        int idx, ridx, cyc, cnt;
        logic [2:0]  rop;
        logic [63:0] ra, rb;

        reset_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 64'd0; req_b = 64'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", {req_ready, resp_valid}, 2'b10);
        chk("rst_result", resp_result, 64'd0);
        chk("rst_status", resp_status, 4'd0);
        chk("rst_alu", {alu_fs, alu_a, alu_b, alu_cin}, 134'd0);
        reset_n = 1'b1;

        run_op(3'd3, 64'd5, 64'd5, 0);
        run_op(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(3'd5, 64'd1, 64'h43, 0);
        run_op(3'd7, 64'd7, 64'd6, 0);
        run_op(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_op(3'd7, 64'h1_0000_0000, 64'h1_0000_0000, 0);
        run_op(3'd4, 64'hF0, 64'hFF, 10);

        // Abort a multiply with a two-cycle reset.
        @(negedge clock);
        req_valid = 1'b1; req_op = 3'd7; req_a = 64'd3; req_b = 64'hFF;
        @(posedge clock); #1; req_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("abort_state", {req_ready, resp_valid}, 2'b10);
        chk("abort_result", resp_result, 64'd0);
        chk("abort_status", resp_status, 4'd0);
        chk("abort_fs", alu_fs, 5'd0);
        reset_n = 1'b1; resp_ready = 1'b1;
        cnt = 0;
        repeat (300) begin @(negedge clock); if (resp_valid) cnt++; end
        chk("abort_no_resp", cnt, 0);
        resp_ready = 1'b0;

        // Back-to-back requests with consumer always ready.
        bop[0] = 3'd0; ba[0] = 64'hFF00_FF00_1234_5678; bb[0] = 64'h0F0F_0F0F_FFFF_0000;
        bop[1] = 3'd1; ba[1] = 64'h0000_00F0_0000_0001; bb[1] = 64'h8000_0000_0000_0100;
        bop[2] = 3'd6; ba[2] = 64'h8000_0000_0000_0000; bb[2] = 64'h0000_0000_0000_003C;
        resp_ready = 1'b1; idx = 0; ridx = 0; cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) begin
                if (ridx < 3) begin
                    ref_model(bop[ridx], ba[ridx], bb[ridx], er, es);
                    chk("b2b_result", resp_result, er);
                    chk("b2b_status", resp_status, es);
                end
                ridx++;
                chk("b2b_no_accept_in_resp", req_ready, 0);
            end
            if (idx < 3) begin
                req_valid = 1'b1; req_op = bop[idx]; req_a = ba[idx]; req_b = bb[idx];
                if (req_ready) begin acc_cyc[idx] = cyc; idx++; end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("b2b_accepts", idx, 3);
        chk("b2b_responses", ridx, 3);
        chk("b2b_interval1", acc_cyc[1] - acc_cyc[0], 3);
        chk("b2b_interval2", acc_cyc[2] - acc_cyc[1], 3);

        for (int k = 0; k < 30; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (rop == 3'd7) rb = rb >> $urandom_range(0, 63);
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request-side controller for the 64-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's function-select, operand and carry-in inputs. It captures the result and the {Z,N,C,V} status, and returns them over a second valid/ready handshake. It also runs 64×64 multiply (low 64 bits) as a multi-cycle shift-add loop through the same ALU. It sits between the datapath control (instruction execute stage) and the combinational ALU.

## Interface
Parameters:
- none (data width fixed at 64, FS width 5, status width 4)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 LSL, 6 LSR, 7 MUL
- req_a  in  64  operand A
- req_b  in  64  operand B (shift amount = req_b[5:0] for LSL/LSR)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_result  out  64  registered result
- resp_status  out  4  registered {Z,N,C,V}
- alu_fs  out  5  to ALU FS: [4:2] select (000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR), [0] invert A, [1] invert B
- alu_a, alu_b  out  64  to ALU operands
- alu_cin  out  1  to ALU carry-in
- alu_f  in  64  ALU result
- alu_cout  in  1  ALU carry-out (unused; C taken from alu_status)
- alu_status  in  4  ALU {Z,N,C,V}

## Operation
- States: IDLE, EXEC, MUL_ADD, MUL_SHL, RESP.
- Reset (reset_n=0 at an edge) forces:
  - state=IDLE, resp_valid=0, resp_result=0, resp_status=0.
  - Internal acc/mcand/mplier=0.
  - ALU drives (alu_fs, alu_a, alu_b, alu_cin) are all 0.
- Reset during EXEC/MUL/RESP aborts the operation. No response is produced.
- req_ready=1 only in IDLE; it is a function of state only.
- Handshakes:
  - Accept = req_valid && req_ready at an edge. req_op/req_a/req_b are registered at that edge.
  - Non-MUL ops go to EXEC; MUL goes to MUL_ADD.
- EXEC:
  - Drive ALU from the registered operands:
    - AND fs=00000, cin=0
    - OR fs=00100, cin=0
    - ADD fs=01000, cin=0
    - SUB fs=01010, cin=1
    - XOR fs=01100, cin=0
    - LSL fs=10000, cin=0
    - LSR fs=10100, cin=0
  - At the edge, capture resp_result=alu_f and resp_status=alu_status, then go to RESP.
- MUL:
  - On accept: acc=0, mcand=req_a, mplier=req_b.
  - MUL_ADD:
    - If mplier==0: resp_result=acc; resp_status={acc==0, acc[63], 0, 0}; go to RESP. ALU drives are 0 in this cycle.
    - Else: drive fs=01000, cin=0, alu_a=acc, alu_b = mplier[0] ? mcand : 0. Capture acc=alu_f and go to MUL_SHL.
  - MUL_SHL:
    - Drive fs=10000, alu_a=mcand, alu_b=1. Capture mcand=alu_f.
    - mplier = mplier>>1 (local logic, not the ALU). Go to MUL_ADD.
  - Overflow beyond bit 63 is discarded. The result is the product mod 2^64.
- RESP:
  - resp_valid=1. resp_result/resp_status are held stable until resp_valid && resp_ready at an edge, then go to IDLE.
  - No request is accepted in the same cycle as response completion.
- In IDLE and RESP, ALU drives are 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from req_* or resp_ready to any output.
- Non-MUL latency: accept at edge E0; resp_valid=1 after edge E1.
- MUL latency: let n = index of the highest set bit of req_b + 1 (n=0 if req_b=0). resp_valid=1 after edge E(2n+1). Examples:
  - B=0 → 1 cycle
  - B=1 → 3 cycles
  - B=3 → 5 cycles
  - B=2^63 → 129 cycles
- Minimum issue interval: 3 cycles for non-MUL ops with resp_ready held high (EXEC, RESP, IDLE).
- Backpressure: resp_ready=0 holds RESP indefinitely, with outputs unchanged.

## Test plan
- Reset with reset_n=0 for 2 cycles in mid-MUL (B=0xFF) → next cycle state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_status=0, alu_fs=0; no response ever appears for the aborted op.
- SUB: A=5, B=5 → resp_valid 1 cycle after accept; result=0, status Z=1,N=0,C=1,V=0; alu_fs=01010 and alu_cin=1 during EXEC.
- ADD overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 → result=0x8000_0000_0000_0000, status N=1,V=1,Z=0,C=0. LSL A=1, B=0x43 → result=8 (only B[5:0] used).
- MUL latency and value:
  - A=7, B=6 → result=42, status 0000, resp_valid 7 cycles after accept.
  - A=0xFFFF_FFFF_FFFF_FFFF, B=0 → result=0, Z=1, 1 cycle.
  - A=2^32, B=2^32 → result=0, Z=1, 67 cycles.
- Backpressure: hold resp_ready=0 for 10 cycles after XOR A=0xF0, B=0xFF → resp_valid stays 1, result=0x0F stable, req_ready=0; raise resp_ready → IDLE next cycle, req_ready=1.
- Back-to-back: req_valid held high with AND, OR, LSR requests and resp_ready=1 → one accept every 3 cycles, responses in order, no request accepted during RESP.
